dm_ctrl: RTL and testbench

Memory-stage controller between the CPU datapath and the 4 KiB byte-enabled data memory. Accepts one load/store request at a time over a req/ready handshake and checks alignment. For stores it drives the memory's word address, byte enables, data and write enable. For loads it extracts and sign/zero-extends the addressed byte, halfword or word from the memory's combinational read port. Completion is signalled with a one-cycle `done` pulse for the multi-cycle control FSM.

---
 rtl/mem_pkg.sv | 39 +++
 rtl/load_ext.sv | 26 ++
 rtl/dm_ctrl.sv | 112 +++++++++++
 tb/tb_dm_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory stage: opcodes, controller states,
// byte-enable patterns and the alignment rule.
package mem_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_W    = 4'b1111;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_H1   = 4'b1100;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    logic err;
    case (op)
      OP_LW, OP_SW:          err = (addr_lo != 2'b00);
      OP_LH, OP_LHU, OP_SH:  err = addr_lo[0];
      default:               err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Picks the addressed byte/halfword out of a memory word and extends it.
module load_ext
  import mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'h0000, half_sel};
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'h000000, byte_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Memory-stage controller: one request per IDLE->ACCESS->DONE pass, drives the
// byte-enabled data memory for stores and extends load data into rdata.
module dm_ctrl
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        ready,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic [9:0]  dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_din,
  output logic        dm_we,
  input  logic [31:0] dm_dout
);

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [9:0]  dm_addr_q;
  logic [3:0]  dm_be_q;
  logic [31:0] dm_din_q;
  logic        dm_we_q;

  logic        accept;
  logic        req_err;
  logic [3:0]  req_be;
  logic [31:0] load_val;

  // Upper address bits are deliberately outside the 4 KiB memory window.
  logic        unused_addr_hi;
  assign unused_addr_hi = ^addr[31:12];

  assign accept  = (state_q == S_IDLE) && req;
  assign req_err = misaligned(op, addr[1:0]);

  always_comb begin
    req_be = BE_NONE;
    case (op)
      OP_SW:   req_be = BE_W;
      OP_SH:   req_be = addr[1] ? BE_H1 : BE_H0;
      OP_SB:   req_be = 4'b0001 << addr[1:0];
      default: req_be = BE_NONE;
    endcase
    if (req_err) req_be = BE_NONE;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  load_ext u_load_ext (
    .op      (op_q),
    .addr_lo (addr_lo_q),
    .word    (dm_dout),
    .result  (load_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_LW;
      addr_lo_q <= 2'b00;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
      dm_addr_q <= 10'h000;
      dm_be_q   <= BE_NONE;
      dm_din_q  <= 32'h0;
      dm_we_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= op;
        addr_lo_q <= addr[1:0];
        err_q     <= req_err;
        dm_addr_q <= addr[11:2];
        dm_be_q   <= req_be;
        dm_din_q  <= wdata;
        dm_we_q   <= is_store(op) && !req_err;
      end
      // The memory commits the write and presents read data on this edge.
      if (state_q == S_ACCESS) begin
        dm_we_q <= 1'b0;
        if (!is_store(op_q) && !err_q) rdata_q <= load_val;
      end
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign done     = (state_q == S_DONE);
  assign addr_err = done && err_q;
  assign rdata    = rdata_q;
  assign dm_addr  = dm_addr_q;
  assign dm_be    = dm_be_q;
  assign dm_din   = dm_din_q;
  assign dm_we    = dm_we_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: byte-addressed shadow-memory model checked every cycle,
// directed cases with literal expectations, then randomized traffic.
module tb_dm_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        ready;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic [9:0]  dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_din;
  logic        dm_we;
  logic [31:0] dm_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ready    (ready),
    .op       (op),
    .addr     (addr),
    .wdata    (wdata),
    .done     (done),
    .rdata    (rdata),
    .addr_err (addr_err),
    .dm_addr  (dm_addr),
    .dm_be    (dm_be),
    .dm_din   (dm_din),
    .dm_we    (dm_we),
    .dm_dout  (dm_dout)
  );

  // Data memory: right-justified data is steered into the enabled lanes.
  logic [31:0] mem [1024] = '{default: 32'h0};
  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_we) begin
      case (dm_be)
        4'hF: mem[dm_addr] <= dm_din;
        4'h3: mem[dm_addr][15:0] <= dm_din[15:0];
        4'hC: mem[dm_addr][31:16] <= dm_din[15:0];
        default:
          for (int k = 0; k < 4; k++)
            if (dm_be[k]) mem[dm_addr][8*k +: 8] <= dm_din[7:0];
      endcase
    end
  end

  // Reference model: flat byte array plus a countdown of cycles until idle.
  logic [7:0]  shadow [4096] = '{default: 8'h0};
  int          busy_left;
  logic [2:0]  m_op;
  logic [11:0] m_a;
  logic        m_store, m_err;
  logic [3:0]  m_be;
  logic [9:0]  m_addr;
  logic [31:0] m_din, m_rdata;

  function automatic logic model_err(input logic [2:0] o, input logic [11:0] a);
    int size;
    size = (o == OP_LW || o == OP_SW) ? 4 : (o == OP_LH || o == OP_LHU || o == OP_SH) ? 2 : 1;
    return (int'(a) % size) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] o, input logic [11:0] a);
    int lane;
    lane = int'(a) % 4;
    if (model_err(o, a)) return 4'h0;
    if (o == OP_SW) return 4'hF;
    if (o == OP_SH) return (lane == 2) ? 4'hC : 4'h3;
    if (o == OP_SB) return 4'(1 << lane);
    return 4'h0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] o, input logic [11:0] a);
    int b0, b1, v;
    b0 = int'(shadow[a]);
    b1 = int'(shadow[12'(int'(a) + 1)]);
    case (o)
      OP_LW:  return {shadow[12'(int'(a) + 3)], shadow[12'(int'(a) + 2)], shadow[12'(int'(a) + 1)], shadow[a]};
      OP_LHU: v = b0 + 256 * b1;
      OP_LH:  begin v = b0 + 256 * b1; if (v >= 32768) v = v - 65536; end
      OP_LBU: v = b0;
      default: begin v = b0; if (v >= 128) v = v - 256; end
    endcase
    return 32'(v);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left <= 0;
      m_op <= OP_LW; m_a <= 12'h0; m_store <= 1'b0; m_err <= 1'b0;
      m_be <= 4'h0; m_addr <= 10'h0; m_din <= 32'h0; m_rdata <= 32'h0;
    end else if (busy_left == 0) begin
      if (req) begin
        busy_left <= 2;
        m_op    <= op;
        m_a     <= addr[11:0];
        m_store <= (op == OP_SW || op == OP_SH || op == OP_SB);
        m_err   <= model_err(op, addr[11:0]);
        m_be    <= model_be(op, addr[11:0]);
        m_addr  <= addr[11:2];
        m_din   <= wdata;
      end
    end else if (busy_left == 2) begin
      busy_left <= 1;
      if (!m_err) begin
        if (m_store) begin
          for (int k = 0; k < ((m_op == OP_SW) ? 4 : (m_op == OP_SH) ? 2 : 1); k++)
            shadow[12'(int'(m_a) + k)] <= m_din[8*k +: 8];
        end else begin
          m_rdata <= model_load(m_op, m_a);
        end
      end
    end else begin
      busy_left <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ready",    {31'b0, ready},    {31'b0, busy_left == 0});
    chk("done",     {31'b0, done},     {31'b0, busy_left == 1});
    chk("addr_err", {31'b0, addr_err}, {31'b0, busy_left == 1 && m_err});
    chk("dm_we",    {31'b0, dm_we},    {31'b0, busy_left == 2 && m_store && !m_err});
    chk("dm_be",    {28'b0, dm_be},    {28'b0, m_be});
    chk("dm_addr",  {22'b0, dm_addr},  {22'b0, m_addr});
    chk("dm_din",   dm_din,            m_din);
    chk("rdata",    rdata,             m_rdata);
  end

  int cyc = 0;
  int acc_q[$];
  always @(posedge clk) begin
    if (rst_n && ready && req) acc_q.push_back(cyc);
    cyc <= cyc + 1;
  end

  task automatic txn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                     output logic [3:0] be_acc, output logic we_acc,
                     output logic done_c2, output logic err_c2);
    int guard;
    guard = 0;
    while (ready !== 1'b1 && guard < 8) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_before_req", {31'b0, ready}, 32'd1);
    req = 1'b1; op = o; addr = a; wdata = d;
    @(posedge clk); #1;
    be_acc = dm_be; we_acc = dm_we;
    req = 1'($urandom_range(0, 1)); op = 3'($urandom); addr = $urandom; wdata = $urandom;
    @(posedge clk); #1;
    done_c2 = done; err_c2 = addr_err;
    req = 1'($urandom_range(0, 1)); op = 3'($urandom); addr = $urandom; wdata = $urandom;
    @(posedge clk); #1;
    req = 1'b0;
    $display("txn op=%0d addr=%h wdata=%h be=%b err=%0d rdata=%h", o, a, d, be_acc, err_c2, rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [3:0]  be_a;
    logic        we_a, dn, er;
    logic [31:0] ra;
    logic [2:0]  ro;

    rst_n = 1'b0; req = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
    #3;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done",  {31'b0, done},  32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_dm_be", {28'b0, dm_be}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    txn(OP_SW, 32'h0000_0010, 32'hDEADBEEF, be_a, we_a, dn, er);
    chk("sw_be", {28'b0, be_a}, 32'hF);
    chk("sw_we", {31'b0, we_a}, 32'd1);
    txn(OP_LW, 32'h0000_0010, 32'h0, be_a, we_a, dn, er);
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    chk("lw_done_c2", {31'b0, dn}, 32'd1);
    txn(OP_SB, 32'h0000_0013, 32'h0000_0080, be_a, we_a, dn, er);
    chk("sb_be", {28'b0, be_a}, 32'h8);
    txn(OP_LB, 32'h0000_0013, 32'h0, be_a, we_a, dn, er);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    txn(OP_LBU, 32'h0000_0013, 32'h0, be_a, we_a, dn, er);
    chk("lbu_rdata", rdata, 32'h00000080);
    txn(OP_SH, 32'h0000_0022, 32'h1234ABCD, be_a, we_a, dn, er);
    chk("sh_be", {28'b0, be_a}, 32'hC);
    txn(OP_LH, 32'h0000_0022, 32'h0, be_a, we_a, dn, er);
    chk("lh_rdata", rdata, 32'hFFFFABCD);
    txn(OP_LHU, 32'h0000_0022, 32'h0, be_a, we_a, dn, er);
    chk("lhu_rdata", rdata, 32'h0000ABCD);
    txn(OP_SW, 32'h0000_0011, 32'h11111111, be_a, we_a, dn, er);
    chk("mis_sw_err", {31'b0, er}, 32'd1);
    chk("mis_sw_done", {31'b0, dn}, 32'd1);
    chk("mis_sw_we", {31'b0, we_a}, 32'd0);
    chk("mis_sw_mem", mem[4], 32'h80ADBEEF);
    txn(OP_LH, 32'h0000_0021, 32'h0, be_a, we_a, dn, er);
    chk("mis_lh_err", {31'b0, er}, 32'd1);
    chk("mis_lh_rdata", rdata, 32'h0000ABCD);

    // Continuous req: accepts land three cycles apart.
    acc_q.delete();
    req = 1'b1; op = OP_LW; addr = 32'h0000_0010; wdata = 32'h0;
    repeat (9) @(posedge clk);
    #1; req = 1'b0;
    chk("hs_count", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() == 3) begin
      chk("hs_gap1", 32'(acc_q[1] - acc_q[0]), 32'd3);
      chk("hs_gap2", 32'(acc_q[2] - acc_q[1]), 32'd3);
    end
    $display("txn handshake accepts=%0d", acc_q.size());
    @(posedge clk); #1;

    // Reset in the middle of a store's ACCESS cycle.
    req = 1'b1; op = OP_SW; addr = 32'h0000_0040; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req = 1'b0;
    chk("acc_we_pre_rst", {31'b0, dm_we}, 32'd1);
    #2; rst_n = 1'b0;
    #1;
    chk("rst_mid_we",    {31'b0, dm_we},    32'd0);
    chk("rst_mid_ready", {31'b0, ready},    32'd1);
    chk("rst_mid_done",  {31'b0, done},     32'd0);
    chk("rst_mid_rdata", rdata,             32'h0);
    chk("rst_mid_addr",  {22'b0, dm_addr},  32'h0);
    chk("rst_mid_din",   dm_din,            32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_ready", {31'b0, ready}, 32'd1);
    $display("txn reset-during-access done=%0d ready=%0d", done, ready);

    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      ra[11:0] = 12'h100 + 12'($urandom_range(0, 31));
      ro = 3'($urandom_range(0, 7));
      txn(ro, ra, $urandom, be_a, we_a, dn, er);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
